// File: rtl/ndma_cfg_sub.sv
// ndma_cfg_sub: OBI-style configuration slave for a simple DMA engine.
// Holds SRC/DST/LEN, launches the engine with a one-cycle start pulse and
// tracks BUSY/DONE with a level interrupt gated by IRQ_EN.
module ndma_cfg_sub #(
    parameter  int unsigned MaxTxSize = 256,
    localparam int unsigned LenBits   = $clog2(MaxTxSize) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_req_i,
    input  logic               cfg_we_i,
    input  logic [31:0]        cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic               cfg_gnt_o,
    output logic               cfg_rvalid_o,
    output logic [31:0]        cfg_rdata_o,
    output logic               cfg_err_o,
    output logic [31:0]        src_addr_o,
    output logic [31:0]        dst_addr_o,
    output logic [LenBits-1:0] len_o,
    output logic               start_o,
    input  logic               tx_done_i,
    output logic               irq_o
);

    localparam logic [7:0] OffSrc    = 8'h00;
    localparam logic [7:0] OffDst    = 8'h04;
    localparam logic [7:0] OffLen    = 8'h08;
    localparam logic [7:0] OffCtrl   = 8'h0C;
    localparam logic [7:0] OffStatus = 8'h10;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LenBits-1:0] len_q, len_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;
    logic               start_q, start_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               busy;
    logic               start_req;  // accepted CTRL write with START=1
    logic               done_clr;   // STATUS write with DONE=1

    // Only the low byte of the address is decoded.
    logic unused_addr;
    assign unused_addr = ^cfg_addr_i[31:8];

    assign busy = (state_q == S_BUSY);

    // Register decode: writes, read data and error for the current request.
    // Misaligned offsets never match a label and fall into the error branch.
    always_comb begin
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        irq_en_d  = irq_en_q;
        rvalid_d  = cfg_req_i;
        rdata_d   = '0;
        err_d     = 1'b0;
        start_req = 1'b0;
        done_clr  = 1'b0;
        if (cfg_req_i) begin
            case (cfg_addr_i[7:0])
                OffSrc: begin
                    if (!cfg_we_i)  rdata_d = src_q;
                    else if (busy)  err_d   = 1'b1;
                    else            src_d   = cfg_wdata_i;
                end
                OffDst: begin
                    if (!cfg_we_i)  rdata_d = dst_q;
                    else if (busy)  err_d   = 1'b1;
                    else            dst_d   = cfg_wdata_i;
                end
                OffLen: begin
                    if (!cfg_we_i)
                        rdata_d = 32'(len_q);
                    else if (busy || (cfg_wdata_i > MaxTxSize))
                        err_d = 1'b1;
                    else
                        len_d = cfg_wdata_i[LenBits-1:0];
                end
                OffCtrl: begin
                    if (!cfg_we_i) begin
                        rdata_d = {30'd0, irq_en_q, 1'b0};
                    end else if (busy && cfg_wdata_i[0]) begin
                        // restart attempt while running: reject whole write
                        err_d = 1'b1;
                    end else begin
                        irq_en_d  = cfg_wdata_i[1];
                        start_req = cfg_wdata_i[0];
                    end
                end
                OffStatus: begin
                    if (!cfg_we_i) rdata_d  = {30'd0, done_q, busy};
                    else           done_clr = cfg_wdata_i[1];
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Transfer FSM plus DONE bookkeeping; engine set of DONE beats W1C.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        done_d  = done_q;
        if (done_clr) done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if (len_q != '0) begin
                        state_d = S_BUSY;
                        start_d = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        // zero-length transfer completes immediately
                        done_d  = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (tx_done_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            start_q  <= start_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cfg_gnt_o    = cfg_req_i;
    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;
    assign cfg_err_o    = err_q;
    assign src_addr_o   = src_q;
    assign dst_addr_o   = dst_q;
    assign len_o        = len_q;
    assign start_o      = start_q;
    assign irq_o        = done_q & irq_en_q;

endmodule

// File: tb/tb_ndma_cfg_sub.sv
// Bench for ndma_cfg_sub: directed scenarios then random traffic, with a
// register-level reference model feeding a response scoreboard.
module tb_ndma_cfg_sub;

    localparam int unsigned MAX = 256;
    localparam int unsigned LB  = $clog2(MAX) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cfg_req_i = 1'b0, cfg_we_i = 1'b0, tx_done_i = 1'b0;
    logic [31:0]   cfg_addr_i = '0, cfg_wdata_i = '0;
    logic          cfg_gnt_o, cfg_rvalid_o, cfg_err_o, start_o, irq_o;
    logic [31:0]   cfg_rdata_o, src_addr_o, dst_addr_o;
    logic [LB-1:0] len_o;

    ndma_cfg_sub #(.MaxTxSize(MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
        .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o), .src_addr_o(src_addr_o),
        .dst_addr_o(dst_addr_o), .len_o(len_o), .start_o(start_o),
        .tx_done_i(tx_done_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    int tests = 0, fails = 0;
    bit started = 0;

    // reference model state (value after the most recently modelled edge)
    logic [31:0] m_src, m_dst;
    int unsigned m_len;
    bit          m_irqen, m_done, m_busy, exp_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_src = 0; m_dst = 0; m_len = 0;
        m_irqen = 0; m_done = 0; m_busy = 0; exp_start = 0;
    endtask

    // Apply one cycle of inputs to the model; queue the expected response.
    task automatic model_step(input bit req, input bit we, input logic [31:0] addr,
                              input logic [31:0] wd, input bit txd, input bit rst);
        rsp_t        r;
        bit          st_req = 0, clr = 0, er = 0;
        logic [31:0] rd = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (req) begin
            if (addr[1:0] != 2'b00) er = 1;
            else case (addr[7:0])
                8'h00: if (!we) rd = m_src; else if (m_busy) er = 1; else m_src = wd;
                8'h04: if (!we) rd = m_dst; else if (m_busy) er = 1; else m_dst = wd;
                8'h08: if (!we) rd = m_len; else if (m_busy || wd > MAX) er = 1; else m_len = wd;
                8'h0C: if (!we) rd = {m_irqen, 1'b0};
                       else if (m_busy && wd[0]) er = 1;
                       else begin m_irqen = wd[1]; st_req = wd[0]; end
                8'h10: if (!we) rd = {m_done, m_busy}; else clr = wd[1];
                default: er = 1;
            endcase
            r.due = cyc + 1; r.rdata = rd; r.err = er;
            exp_q.push_back(r);
        end
        exp_start = 0;
        if (clr) m_done = 0;
        if (!m_busy && st_req) begin
            if (m_len != 0) begin m_busy = 1; exp_start = 1; m_done = 0; end
            else m_done = 1;
        end else if (m_busy && txd) begin
            m_busy = 0; m_done = 1;
        end
    endtask

    task automatic check_outs();
        chk("start_o", start_o, exp_start);
        chk("irq_o", irq_o, m_done & m_irqen);
        chk("src_addr_o", src_addr_o, m_src);
        chk("dst_addr_o", dst_addr_o, m_dst);
        chk("len_o", 32'(len_o), m_len);
    endtask

    // One bus cycle, entered and left at a falling edge.
    task automatic cycle(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input bit txd, input bit rst);
        check_outs();
        cfg_req_i = req; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wd;
        tx_done_i = txd; rst_i = rst;
        model_step(req, we, addr, wd, txd, rst);
        #1;
        chk("gnt", cfg_gnt_o, req);
        @(negedge clk_i);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1, 1, a, d, 0, 0);
    endtask
    task automatic rd(input logic [31:0] a);
        cycle(1, 0, a, 0, 0, 0);
    endtask
    task automatic idle(input bit txd);
        cycle(0, 0, 0, 0, txd, 0);
    endtask

    // Response monitor: every rvalid must match the oldest expectation on time.
    always @(negedge clk_i) begin
        if (started) begin
            if (cfg_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected: got rvalid with no request pending (cycle %0d)", cyc);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_cycle", cyc, e.due);
                    chk("rsp_rdata", cfg_rdata_o, e.rdata);
                    chk("rsp_err", cfg_err_o, e.err);
                end
            end else begin
                chk("idle_rdata", cfg_rdata_o, 0);
                chk("idle_err", cfg_err_o, 0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    tests++; fails++;
                    $display("FAIL rsp_missing: no rvalid, expected by cycle %0d (now %0d)", exp_q[0].due, cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] r, addr, wd;
        logic [7:0]  offs [8];
        bit          req, we, txd, rst;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        model_reset();
        started = 1;

        // basic register write / read-back
        wr(32'h00, 32'h1000); wr(32'h04, 32'h2000); wr(32'h08, 16);
        rd(32'h00); rd(32'h04); rd(32'h08);
        chk("src_value", src_addr_o, 32'h1000);
        chk("len_value", 32'(len_o), 16);
        // start with IRQ_EN, illegal writes while busy, completion, W1C
        wr(32'h0C, 32'h3);
        chk("start_pulse", start_o, 1);
        rd(32'h10);
        chk("start_single", start_o, 0);
        wr(32'h00, 32'hDEAD); wr(32'h0C, 32'h1); rd(32'h00);
        idle(1);
        chk("irq_set", irq_o, 1);
        rd(32'h10);
        wr(32'h10, 32'h2);
        chk("irq_cleared", irq_o, 0);
        // zero-length start, oversize length, bad offsets
        wr(32'h08, 0); wr(32'h0C, 32'h1); rd(32'h10);
        wr(32'h08, MAX + 1); rd(32'h08); wr(32'h08, MAX);
        rd(32'h14); rd(32'h02);
        // engine completion coincident with DONE W1C: set wins
        wr(32'h0C, 32'h1); idle(0);
        cycle(1, 1, 32'h10, 32'h2, 1, 0);
        rd(32'h10);
        // reset mid-transfer with a request in flight, then a stray done
        wr(32'h0C, 32'h3); idle(0);
        cycle(1, 0, 32'h00, 0, 0, 1);
        chk("rst_rvalid", cfg_rvalid_o, 0);
        chk("rst_len", 32'(len_o), 0);
        rd(32'h10); idle(1); rd(32'h10); idle(0);

        // random traffic
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h02, 8'h00};
        for (int i = 0; i < 3000; i++) begin
            r    = $urandom;
            rst  = ($urandom_range(0, 299) == 0);
            req  = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1);
            addr = {r[31:8], offs[$urandom_range(0, 7)]};
            if ($urandom_range(0, 15) == 0) addr[7:0] = r[7:0];
            case (addr[7:0])
                8'h08: case ($urandom_range(0, 4))
                    0: wd = 0;
                    1: wd = MAX;
                    2: wd = MAX + 1;
                    3: wd = $urandom_range(1, MAX);
                    default: wd = $urandom;
                endcase
                8'h0C, 8'h10: wd = $urandom_range(0, 3);
                default: wd = $urandom;
            endcase
            txd = m_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
            cycle(req, we, addr, wd, txd, rst);
        end
        idle(0); idle(0);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ndma_cfg_sub.md
NDMA_CFG_SUB -- requirements
Module: ndma_cfg_sub

Interface
Parameters:
REQ-001 SHALL have parameter MaxTxSize, default 256, the largest legal transfer length in words.
REQ-002 SHALL have localparam LenBits = $clog2(MaxTxSize)+1, the width of the length register (holds 0..MaxTxSize).

Ports:
REQ-003 SHALL have clk_i  input  1  clock; the single clock domain.
REQ-004 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have cfg_req_i  input  1  OBI request.
REQ-006 SHALL have cfg_we_i  input  1  write enable.
REQ-007 SHALL have cfg_addr_i  input  32  byte address; only [7:0] decoded.
REQ-008 SHALL have cfg_wdata_i  input  32  write data.
REQ-009 SHALL have cfg_gnt_o  output  1  grant.
REQ-010 SHALL have cfg_rvalid_o  output  1  response valid.
REQ-011 SHALL have cfg_rdata_o  output  32  read data.
REQ-012 SHALL have cfg_err_o  output  1  response error, valid with cfg_rvalid_o.
REQ-013 SHALL have src_addr_o  output  32  source start address.
REQ-014 SHALL have dst_addr_o  output  32  destination start address.
REQ-015 SHALL have len_o  output  LenBits  transfer length in words.
REQ-016 SHALL have start_o  output  1  one-cycle transfer start pulse to the engine.
REQ-017 SHALL have tx_done_i  input  1  one-cycle completion pulse from the engine.
REQ-018 SHALL have irq_o  output  1  level completion interrupt.

Function
REQ-019 SHALL assert cfg_gnt_o combinationally equal to cfg_req_i (always ready, no wait states).
REQ-020 SHALL assert cfg_rvalid_o for exactly one cycle, the cycle after each granted request, with cfg_rdata_o/cfg_err_o registered alongside; back-to-back requests give back-to-back responses.
REQ-021 SHALL drive cfg_rdata_o = 0 and cfg_err_o = 0 whenever cfg_rvalid_o = 0; write responses have cfg_rdata_o = 0.
REQ-022 SHALL map offsets cfg_addr_i[7:0]: 0x00 SRC (RW 32b), 0x04 DST (RW 32b), 0x08 LEN (RW, LenBits zero-extended), 0x0C CTRL (bit0 START write-1 reads 0, bit1 IRQ_EN RW), 0x10 STATUS (bit0 BUSY RO, bit1 DONE W1C).
REQ-023 SHALL respond to any other offset, or a cfg_addr_i[1:0] != 0, with cfg_err_o = 1, read data 0, no state change.
REQ-024 SHALL keep FSM states IDLE and BUSY; BUSY is STATUS.BUSY.
REQ-025 IDLE -> BUSY on a CTRL write with wdata[0] = 1 and LEN != 0; start_o pulses in the cycle after that write is granted (the response cycle).
REQ-026 A START write with LEN = 0 in IDLE SHALL not pulse start_o, stay IDLE and set DONE in the next cycle.
REQ-027 BUSY -> IDLE on tx_done_i = 1; DONE set in the next cycle; tx_done_i in IDLE SHALL be ignored.
REQ-028 In BUSY, writes to SRC, DST, LEN and CTRL writes with START = 1 SHALL be ignored and answered with cfg_err_o = 1; IRQ_EN bit of such CTRL writes is also not applied; reads are unaffected.
REQ-029 LEN writes with wdata > MaxTxSize SHALL be ignored with cfg_err_o = 1.
REQ-030 src_addr_o, dst_addr_o, len_o SHALL reflect the register values continuously; they are stable throughout BUSY.
REQ-031 A STATUS write with wdata[1] = 1 SHALL clear DONE; if DONE is set by the engine in the same cycle, set wins.
REQ-032 irq_o SHALL equal DONE AND IRQ_EN, registered-free from those flops.
REQ-033 A START write while DONE = 1 SHALL clear DONE in the same update in which BUSY is entered.

Reset
REQ-034 On rst_i = 1 at a clock edge all registers SHALL clear: SRC/DST/LEN = 0, IRQ_EN = 0, DONE = 0, state IDLE, cfg_rvalid_o = 0, start_o = 0, irq_o = 0.
REQ-035 Reset asserted mid-transfer SHALL return to IDLE without a response for the in-flight request and without an irq; a later tx_done_i is ignored.

Verification
REQ-036 Write SRC=0x1000, DST=0x2000, LEN=16, read back all -> rvalid 1 cycle after each gnt, rdata 0x1000/0x2000/16, err 0.
REQ-037 CTRL=0x3 -> start_o single pulse next cycle, STATUS=0x1; tx_done_i pulse -> STATUS=0x2, irq_o=1; STATUS write 0x2 -> irq_o=0.
REQ-038 While BUSY write SRC=0xDEAD and CTRL=0x1 -> err=1, SRC still 0x1000, no start_o.
REQ-039 LEN=0 then CTRL=0x1 -> no start_o, DONE=1; LEN=MaxTxSize+1 -> err=1, LEN unchanged.
REQ-040 Read offset 0x14 and 0x02 -> err=1, rdata 0; tx_done_i coincident with DONE W1C -> DONE stays 1.
REQ-041 rst_i asserted during BUSY -> all outputs 0 next cycle, STATUS reads 0x0.
